// File: rtl/cache_replacement_unit.sv
// cache_replacement_unit: per-set PLRU/round-robin/LFSR victim selector (req valid/ready in, registered victim out, hit/commit updates, flush)
module cache_replacement_unit #(
  parameter int N_WAY = 4,
  parameter int N_SETS = 64,
  parameter int POLICY = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int WAY_W = $clog2(N_WAY),
  localparam int SET_W = N_SETS > 1 ? $clog2(N_SETS) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [SET_W-1:0] req_set_i,
  input  logic [N_WAY-1:0] valid_vec_i,
  input  logic [N_WAY-1:0] lock_vec_i,
  output logic             victim_valid_o,
  input  logic             victim_ready_i,
  output logic [N_WAY-1:0] victim_vec_o,
  output logic [WAY_W-1:0] victim_idx_o,
  output logic             victim_all_locked_o,
  input  logic             access_valid_i,
  input  logic [SET_W-1:0] access_set_i,
  input  logic [WAY_W-1:0] access_way_i
);
  function automatic logic [WAY_W-1:0] plru_pick(input logic [N_WAY-2:0] t);
    logic [WAY_W-1:0] w;
    logic b;
    int n;
    w = '0;
    n = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = 1'b0;
      for (int k = 0; k < N_WAY - 1; k++) b = (k == n) ? t[k] : b;
      w[WAY_W-1-l] = b;
      n = b ? 2 * n + 2 : 2 * n + 1;
    end
    return w;
  endfunction
  function automatic logic [N_WAY-2:0] plru_upd(input logic [N_WAY-2:0] t, input logic [WAY_W-1:0] w);
    logic [N_WAY-2:0] r;
    int n;
    r = t;
    n = 0;
    for (int l = 0; l < WAY_W; l++) begin
      for (int k = 0; k < N_WAY - 1; k++) r[k] = (k == n) ? ~w[WAY_W-1-l] : r[k];
      n = w[WAY_W-1-l] ? 2 * n + 2 : 2 * n + 1;
    end
    return r;
  endfunction
  logic [N_WAY-2:0] plru_q [N_SETS];
  logic [N_WAY-2:0] plru_d [N_SETS];
  logic [WAY_W-1:0] rr_q [N_SETS];
  logic [WAY_W-1:0] rr_d [N_SETS];
  logic [15:0]      lfsr_q, lfsr_d;
  logic             victim_valid_q, victim_valid_d;
  logic [N_WAY-1:0] victim_vec_q, victim_vec_d;
  logic [WAY_W-1:0] victim_idx_q, victim_idx_d;
  logic             victim_all_locked_q, victim_all_locked_d;
  logic [SET_W-1:0] victim_set_q, victim_set_d;
  logic             accept, commit, all_locked;
  logic [N_WAY-1:0] cand, inv;
  logic [WAY_W-1:0] pick, sel;
  assign req_ready_o = !flush_i && (!victim_valid_q || victim_ready_i);
  always_comb begin
    accept = req_valid_i && req_ready_o;
    commit = victim_valid_q && victim_ready_i && !victim_all_locked_q && !flush_i;
    cand = ~lock_vec_i;
    inv = ~valid_vec_i & cand;
    all_locked = ~|cand;
    pick = POLICY == 1 ? rr_q[req_set_i] : POLICY == 2 ? lfsr_q[WAY_W-1:0] : plru_pick(plru_q[req_set_i]);
    sel = '0;
    for (int k = N_WAY - 1; k >= 0; k--) sel = inv[k] ? WAY_W'(k) : sel;
    for (int k = N_WAY - 1; k >= 0; k--) sel = (~|inv && cand[pick + WAY_W'(k)]) ? pick + WAY_W'(k) : sel;
    plru_d = plru_q;
    rr_d = rr_q;
    if (access_valid_i) begin
      plru_d[access_set_i] = plru_upd(plru_d[access_set_i], access_way_i);
      rr_d[access_set_i] = access_way_i + 1'b1;
    end
    // commit applied last so it wins over a same-set hit
    if (commit) begin
      plru_d[victim_set_q] = plru_upd(plru_d[victim_set_q], victim_idx_q);
      rr_d[victim_set_q] = victim_idx_q + 1'b1;
    end
    if (flush_i) begin
      plru_d = '{default: '0};
      rr_d = '{default: '0};
    end
    lfsr_d = accept ? ({1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000)) : lfsr_q;
    victim_valid_d = accept ? 1'b1 : (flush_i || victim_ready_i) ? 1'b0 : victim_valid_q;
    victim_vec_d = accept ? (all_locked ? '0 : N_WAY'(1) << sel) : victim_vec_q;
    victim_idx_d = accept ? (all_locked ? '0 : sel) : victim_idx_q;
    victim_all_locked_d = accept ? all_locked : victim_all_locked_q;
    victim_set_d = accept ? req_set_i : victim_set_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      plru_q <= '{default: '0};
      rr_q <= '{default: '0};
      lfsr_q <= LFSR_SEED;
      victim_valid_q <= 1'b0;
      victim_vec_q <= '0;
      victim_idx_q <= '0;
      victim_all_locked_q <= 1'b0;
      victim_set_q <= '0;
    end else begin
      plru_q <= plru_d;
      rr_q <= rr_d;
      lfsr_q <= lfsr_d;
      victim_valid_q <= victim_valid_d;
      victim_vec_q <= victim_vec_d;
      victim_idx_q <= victim_idx_d;
      victim_all_locked_q <= victim_all_locked_d;
      victim_set_q <= victim_set_d;
    end
  end
  assign victim_valid_o = victim_valid_q;
  assign victim_vec_o = victim_vec_q;
  assign victim_idx_o = victim_idx_q;
  assign victim_all_locked_o = victim_all_locked_q;
  assert property (@(posedge clk_i) disable iff (rst_i) req_valid_i |-> 32'(req_set_i) < N_SETS);
  assert property (@(posedge clk_i) disable iff (rst_i) access_valid_i |-> 32'(access_set_i) < N_SETS);
endmodule

// File: tb/tb_cache_replacement_unit.sv
// tb_cache_replacement_unit: table vectors, corner sequences and random traffic against a reference model for all three policies
module tb_cache_replacement_unit;
  logic clk = 1'b0;
  logic rst, flush, req_valid, vready, acc_valid;
  logic [5:0] req_set, acc_set;
  logic [3:0] valid_vec, lock_vec;
  logic [1:0] acc_way;
  logic rdy [3];
  logic vv [3];
  logic [3:0] vvec [3];
  logic [1:0] vidx [3];
  logic vall [3];
  int n_checks = 0;
  int n_errors = 0;
  int mt [64][3];
  int mr [64];
  logic [15:0] ml;
  bit mv, mal;
  int mset;
  int midx [3];
  logic [3:0] mvec [3];
  always #5 clk = ~clk;
  cache_replacement_unit #(.N_WAY(4), .N_SETS(64), .POLICY(0)) u_p0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_valid_i(req_valid), .req_ready_o(rdy[0]),
    .req_set_i(req_set), .valid_vec_i(valid_vec), .lock_vec_i(lock_vec), .victim_valid_o(vv[0]),
    .victim_ready_i(vready), .victim_vec_o(vvec[0]), .victim_idx_o(vidx[0]), .victim_all_locked_o(vall[0]),
    .access_valid_i(acc_valid), .access_set_i(acc_set), .access_way_i(acc_way));
  cache_replacement_unit #(.N_WAY(4), .N_SETS(64), .POLICY(1)) u_p1 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_valid_i(req_valid), .req_ready_o(rdy[1]),
    .req_set_i(req_set), .valid_vec_i(valid_vec), .lock_vec_i(lock_vec), .victim_valid_o(vv[1]),
    .victim_ready_i(vready), .victim_vec_o(vvec[1]), .victim_idx_o(vidx[1]), .victim_all_locked_o(vall[1]),
    .access_valid_i(acc_valid), .access_set_i(acc_set), .access_way_i(acc_way));
  cache_replacement_unit #(.N_WAY(4), .N_SETS(64), .POLICY(2)) u_p2 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .req_valid_i(req_valid), .req_ready_o(rdy[2]),
    .req_set_i(req_set), .valid_vec_i(valid_vec), .lock_vec_i(lock_vec), .victim_valid_o(vv[2]),
    .victim_ready_i(vready), .victim_vec_o(vvec[2]), .victim_idx_o(vidx[2]), .victim_all_locked_o(vall[2]),
    .access_valid_i(acc_valid), .access_set_i(acc_set), .access_way_i(acc_way));
  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  function automatic int tree_pick(input int s);
    int n = 0;
    for (int l = 0; l < 2; l++) n = 2 * n + 1 + mt[s][n];
    return n - 3;
  endfunction
  task automatic tree_touch(input int s, input int w);
    int n = 0;
    for (int l = 0; l < 2; l++) begin
      int d = (w >> (1 - l)) & 1;
      mt[s][n] = 1 - d;
      n = 2 * n + 1 + d;
    end
  endtask
  function automatic int sel_m(input int p, input int s, input logic [3:0] v, input logic [3:0] lk);
    int pk;
    for (int w = 0; w < 4; w++) if (!v[w] && !lk[w]) return w;
    pk = p == 0 ? tree_pick(s) : p == 1 ? mr[s] : int'(ml % 16'd4);
    for (int k = 0; k < 4; k++) if (!lk[(pk + k) % 4]) return (pk + k) % 4;
    return 0;
  endfunction
  task automatic model_reset();
    for (int s = 0; s < 64; s++) begin
      mr[s] = 0;
      for (int n = 0; n < 3; n++) mt[s][n] = 0;
    end
    ml = 16'hACE1;
    mv = 0;
    mal = 0;
    mset = 0;
    for (int i = 0; i < 3; i++) begin
      midx[i] = 0;
      mvec[i] = 4'b0;
    end
  endtask
  task automatic step();
    int nidx [3];
    bit acc, com, er;
    #1;
    er = !flush && (!mv || vready);
    if (!rst) for (int i = 0; i < 3; i++) chk($sformatf("req_ready p%0d", i), int'(rdy[i]), int'(er));
    if (rst) model_reset();
    else begin
      acc = req_valid && er;
      com = mv && vready && !mal && !flush;
      for (int i = 0; i < 3; i++) nidx[i] = sel_m(i, int'(req_set), valid_vec, lock_vec);
      if (acc_valid) begin
        tree_touch(int'(acc_set), int'(acc_way));
        mr[int'(acc_set)] = (int'(acc_way) + 1) % 4;
      end
      if (com) begin
        tree_touch(mset, midx[0]);
        mr[mset] = (midx[1] + 1) % 4;
      end
      if (flush) begin
        for (int s = 0; s < 64; s++) begin
          mr[s] = 0;
          for (int n = 0; n < 3; n++) mt[s][n] = 0;
        end
      end
      if (acc) begin
        bit b = ml[0];
        ml = ml >> 1;
        if (b) ml = ml ^ 16'hB400;
        mv = 1;
        mal = (lock_vec == 4'hF);
        mset = int'(req_set);
        for (int i = 0; i < 3; i++) begin
          midx[i] = mal ? 0 : nidx[i];
          mvec[i] = mal ? 4'b0 : 4'(1 << midx[i]);
        end
      end else if (flush || vready) mv = 0;
    end
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("victim_valid p%0d", i), int'(vv[i]), int'(mv));
      chk($sformatf("victim_vec p%0d", i), int'(vvec[i]), int'(mvec[i]));
      chk($sformatf("victim_idx p%0d", i), int'(vidx[i]), midx[i]);
      chk($sformatf("all_locked p%0d", i), int'(vall[i]), int'(mal));
    end
  endtask
  task automatic idle();
    rst = 0; flush = 0; req_valid = 0; vready = 0; acc_valid = 0;
    req_set = '0; acc_set = '0; acc_way = '0; valid_vec = 4'hF; lock_vec = 4'h0;
  endtask
  task automatic request(input int s, input logic [3:0] v, input logic [3:0] lk);
    idle();
    req_valid = 1;
    req_set = 6'(s);
    valid_vec = v;
    lock_vec = lk;
    step();
  endtask
  task automatic take();
    idle();
    vready = 1;
    step();
  endtask
  typedef struct {
    int set;
    logic [3:0] v;
    logic [3:0] lk;
    int e0;
    int e1;
    bit al;
  } vec_t;
  vec_t tbl [12];
  initial begin
    tbl[0]  = '{2,  4'b1011, 4'b0000, 2, 2, 0};
    tbl[1]  = '{5,  4'b1111, 4'b0000, 0, 0, 0};
    tbl[2]  = '{5,  4'b1111, 4'b0000, 2, 1, 0};
    tbl[3]  = '{5,  4'b1111, 4'b0000, 1, 2, 0};
    tbl[4]  = '{5,  4'b1111, 4'b0000, 3, 3, 0};
    tbl[5]  = '{5,  4'b1111, 4'b0000, 0, 0, 0};
    tbl[6]  = '{9,  4'b1111, 4'b0001, 1, 1, 0};
    tbl[7]  = '{10, 4'b1111, 4'b1111, 0, 0, 1};
    tbl[8]  = '{10, 4'b1111, 4'b0000, 0, 0, 0};
    tbl[9]  = '{9,  4'b1111, 4'b0000, 2, 2, 0};
    tbl[10] = '{11, 4'b0110, 4'b0001, 3, 3, 0};
    tbl[11] = '{9,  4'b1111, 4'b0001, 1, 3, 0};
    idle();
    rst = 1;
    step();
    step();
    chk("reset victim_valid", int'(vv[0]), 0);
    chk("reset victim_vec", int'(vvec[0]), 0);
    for (int t = 0; t < 12; t++) begin
      request(tbl[t].set, tbl[t].v, tbl[t].lk);
      chk($sformatf("tbl%0d plru idx", t), int'(vidx[0]), tbl[t].e0);
      chk($sformatf("tbl%0d rr idx", t), int'(vidx[1]), tbl[t].e1);
      chk($sformatf("tbl%0d plru vec", t), int'(vvec[0]), tbl[t].al ? 0 : 1 << tbl[t].e0);
      chk($sformatf("tbl%0d all_locked", t), int'(vall[0]), int'(tbl[t].al));
      take();
    end
    request(30, 4'hF, 4'h0);
    for (int c = 0; c < 3; c++) begin
      idle();
      req_valid = 1;
      req_set = 6'd31;
      valid_vec = 4'b0111;
      step();
      chk("stall valid", int'(vv[0]), 1);
      chk("stall idx", int'(vidx[0]), 0);
      chk("stall vec", int'(vvec[0]), 1);
      chk("stall ready", int'(rdy[0]), 0);
    end
    take();
    request(20, 4'hF, 4'h0);
    idle();
    vready = 1;
    acc_valid = 1;
    acc_set = 6'd20;
    acc_way = 2'd3;
    step();
    request(20, 4'hF, 4'h0);
    chk("simul plru idx", int'(vidx[0]), 2);
    chk("simul rr idx", int'(vidx[1]), 1);
    take();
    request(5, 4'hF, 4'h0);
    chk("preflush plru idx", int'(vidx[0]), 2);
    idle();
    flush = 1;
    vready = 1;
    req_valid = 1;
    req_set = 6'd6;
    valid_vec = 4'b1110;
    step();
    chk("flush drops victim", int'(vv[0]), 0);
    request(5, 4'hF, 4'h0);
    chk("postflush plru idx", int'(vidx[0]), 0);
    chk("postflush rr idx", int'(vidx[1]), 0);
    take();
    request(3, 4'hF, 4'h0);
    idle();
    rst = 1;
    step();
    chk("midreset valid", int'(vv[0]), 0);
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 29) == 0);
      req_valid = ($urandom_range(0, 2) != 0);
      req_set = 6'($urandom_range(0, 7));
      valid_vec = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      lock_vec = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'h0;
      vready = ($urandom_range(0, 3) != 0);
      acc_valid = ($urandom_range(0, 2) == 0);
      acc_set = 6'($urandom_range(0, 7));
      acc_way = 2'($urandom);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
